// File: rtl/spi_flash_read_master.sv
// SPI/QSPI fast-read initiator (SCK mode 0): one read request becomes one flash
// transaction, bytes stream out on resp_*. Define SPI_FLASH_ADDR4_EN for 4-byte addressing.
module spi_flash_read_master #(
    parameter int CLK_DIV        = 2,
    parameter int LEN_BITS       = 8,
    parameter int CS_HIGH_CYCLES = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [31:0]         req_addr,
    input  logic [LEN_BITS-1:0] req_len,
    input  logic                req_quad,
    output logic                resp_valid,
    output logic [7:0]          resp_data,
    output logic                resp_last,
    input  logic                resp_ready,
    output logic                sck,
    output logic                cs,
    output logic [3:0]          dq_out,
    output logic [3:0]          dq_drive,
    input  logic [3:0]          dq_in
);
`ifdef SPI_FLASH_ADDR4_EN
    localparam int         ADDR_BITS  = 32;
    localparam logic [7:0] CMD_SINGLE = 8'h0C;
    localparam logic [7:0] CMD_QUAD   = 8'hEC;
`else
    localparam int         ADDR_BITS  = 24;
    localparam logic [7:0] CMD_SINGLE = 8'h0B;
    localparam logic [7:0] CMD_QUAD   = 8'hEB;
    logic unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:ADDR_BITS];
`endif
    localparam int         TXW      = 8 + ADDR_BITS;
    localparam int         CSW      = $clog2(CS_HIGH_CYCLES + 1);
    localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, CS_HOLD} state_t;
    state_t state, state_d;

    logic [7:0]          div_cnt;
    logic [5:0]          bit_cnt;
    logic [5:0]          byte_sck;
    logic [TXW-1:0]      tx_sr;
    logic [7:0]          rx_sr, rx_next;
    logic [LEN_BITS-1:0] len_cnt;
    logic [CSW-1:0]      cs_cnt;
    logic                quad_q, fin;
    logic                active, accept, stall, lo_end, hi_end, bit_last;

    assign active    = state inside {CMD, ADDR, DUMMY, DATA};
    assign req_ready = (state == IDLE) && (cs_cnt == '0);
    assign accept    = req_valid && req_ready;
    assign byte_sck  = quad_q ? 6'd2 : 6'd8;
    assign bit_last  = (bit_cnt == 6'd1);
    // Hold SCK low before the first rising edge of a byte while the output slot is still full.
    assign stall     = (state == DATA) && !fin && (bit_cnt == byte_sck) && resp_valid && !resp_ready;
    assign lo_end    = active && !sck && (div_cnt == DIV_LAST) && !stall;
    assign hi_end    = active && sck && (div_cnt == DIV_LAST);
    assign rx_next   = quad_q ? {rx_sr[3:0], dq_in} : {rx_sr[6:0], dq_in[1]};

    always_comb begin
        state_d  = state;
        cs       = 1'b1;
        dq_out   = 4'b0000;
        dq_drive = 4'b0000;
        case (state)
            IDLE: if (accept && req_len != '0) state_d = CMD;
            CMD: begin
                cs       = 1'b0;
                dq_out   = {3'b000, tx_sr[TXW-1]};
                dq_drive = 4'b0001;
                if (hi_end && bit_last) state_d = ADDR;
            end
            ADDR: begin
                cs = 1'b0;
                if (quad_q) begin
                    dq_out   = tx_sr[TXW-1 -: 4];
                    dq_drive = 4'b1111;
                end else begin
                    dq_out   = {3'b000, tx_sr[TXW-1]};
                    dq_drive = 4'b0001;
                end
                if (hi_end && bit_last) state_d = DUMMY;
            end
            DUMMY: begin
                cs = 1'b0;
                if (hi_end && bit_last) state_d = DATA;
            end
            DATA: begin
                cs = 1'b0;
                // fin: the last byte is done, one trailing low phase precedes CS rise
                if (fin && lo_end) state_d = CS_HOLD;
            end
            CS_HOLD: if (cs_cnt <= CSW'(1)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            sck        <= 1'b0;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            tx_sr      <= '0;
            rx_sr      <= '0;
            len_cnt    <= '0;
            quad_q     <= 1'b0;
            fin        <= 1'b0;
            cs_cnt     <= CSW'(CS_HIGH_CYCLES);
            resp_valid <= 1'b0;
            resp_data  <= '0;
            resp_last  <= 1'b0;
        end else begin
            state <= state_d;
            if (cs_cnt != '0) cs_cnt <= cs_cnt - CSW'(1);
            if (resp_valid && resp_ready) begin
                resp_valid <= 1'b0;
                resp_last  <= 1'b0;
            end
            if (accept) begin
                tx_sr   <= {req_quad ? CMD_QUAD : CMD_SINGLE, req_addr[ADDR_BITS-1:0]};
                len_cnt <= req_len;
                quad_q  <= req_quad;
                bit_cnt <= 6'd8;
                div_cnt <= '0;
                sck     <= 1'b0;
                fin     <= 1'b0;
            end
            if (active && !stall) begin
                if (div_cnt != DIV_LAST) begin
                    div_cnt <= div_cnt + 8'd1;
                end else if (!sck) begin
                    div_cnt <= '0;
                    if (fin) begin
                        cs_cnt <= CSW'(CS_HIGH_CYCLES - 1);
                    end else begin
                        sck <= 1'b1;
                        if (state == DATA) begin
                            rx_sr <= rx_next;
                            if (bit_last) begin
                                resp_data  <= rx_next;
                                resp_valid <= 1'b1;
                                resp_last  <= (len_cnt == LEN_BITS'(1));
                                len_cnt    <= len_cnt - LEN_BITS'(1);
                            end
                        end
                    end
                end else begin
                    div_cnt <= '0;
                    sck     <= 1'b0;
                    bit_cnt <= bit_cnt - 6'd1;
                    case (state)
                        CMD: begin
                            tx_sr <= tx_sr << 1;
                            if (bit_last) bit_cnt <= quad_q ? 6'(ADDR_BITS / 4) : 6'(ADDR_BITS);
                        end
                        ADDR: begin
                            tx_sr <= quad_q ? (tx_sr << 4) : (tx_sr << 1);
                            if (bit_last) bit_cnt <= 6'd8;
                        end
                        DUMMY: if (bit_last) bit_cnt <= byte_sck;
                        DATA: if (bit_last) begin
                            if (len_cnt == '0) fin <= 1'b1;
                            else bit_cnt <= byte_sck;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_flash_read_master.sv
// Bench for spi_flash_read_master: behavioural flash slave, expected-byte queue
// checked on every handshake, plus directed literal expectations.
module tb_spi_flash_read_master;
    localparam int CLK_DIV  = 2;
    localparam int LEN_BITS = 8;
    localparam int CSH      = 4;
`ifdef SPI_FLASH_ADDR4_EN
    localparam int         AB  = 32;
    localparam logic [7:0] C_S = 8'h0C;
    localparam logic [7:0] C_Q = 8'hEC;
`else
    localparam int         AB  = 24;
    localparam logic [7:0] C_S = 8'h0B;
    localparam logic [7:0] C_Q = 8'hEB;
`endif

    logic                clock = 1'b0;
    logic                reset_n = 1'b1;
    logic                req_valid = 1'b0;
    logic                req_ready;
    logic [31:0]         req_addr = '0;
    logic [LEN_BITS-1:0] req_len = '0;
    logic                req_quad = 1'b0;
    logic                resp_valid;
    logic [7:0]          resp_data;
    logic                resp_last;
    logic                resp_ready = 1'b1;
    logic                sck, cs;
    logic [3:0]          dq_out, dq_drive;
    logic [3:0]          dq_in = 4'h0;

    spi_flash_read_master #(.CLK_DIV(CLK_DIV), .LEN_BITS(LEN_BITS), .CS_HIGH_CYCLES(CSH)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_len(req_len), .req_quad(req_quad),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_last(resp_last),
        .resp_ready(resp_ready),
        .sck(sck), .cs(cs), .dq_out(dq_out), .dq_drive(dq_drive), .dq_in(dq_in)
    );

    always #5 clock = ~clock;

    int pass_cnt = 0, total_cnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Flash model: memory, decoded command/address, per-transaction SCK count
    logic [7:0]  mem [256];
    int          rises = 0, bad = 0, n_txn = 0, last_rises = 0, last_bad = 0;
    logic [7:0]  f_cmd = '0, last_cmd = '0;
    logic [31:0] f_addr = '0, last_addr = '0;

    always @(posedge sck or posedge cs) begin
        if (cs) begin
            last_rises = rises; last_bad = bad; last_cmd = f_cmd; last_addr = f_addr;
            n_txn++; rises = 0; bad = 0; f_cmd = '0; f_addr = '0;
        end else begin
            rises++;
            if (rises <= 8) begin
                f_cmd = {f_cmd[6:0], dq_out[0]};
                if (dq_drive != 4'b0001) bad++;
            end else if (f_cmd == C_Q && rises <= 8 + AB / 4) begin
                f_addr = {f_addr[27:0], dq_out};
                if (dq_drive != 4'b1111) bad++;
            end else if (f_cmd != C_Q && rises <= 8 + AB) begin
                f_addr = {f_addr[30:0], dq_out[0]};
                if (dq_drive != 4'b0001) bad++;
            end else if (dq_drive != 4'b0000) bad++;
        end
    end

    always @(negedge sck) begin
        int d0, k;
        logic [7:0] b;
        logic q;
        q  = (f_cmd == C_Q);
        d0 = q ? 16 + AB / 4 : 16 + AB;
        if (!cs && rises >= d0) begin
            k = rises - d0;
            b = mem[8'(f_addr + 32'(q ? k / 2 : k / 8))];
            if (q) dq_in = k[0] ? b[3:0] : b[7:4];
            else   dq_in = {2'b00, b[3'(7 - k % 8)], 1'b0};
        end
    end

    // Expected response stream: the stimulus appends, the compare process consumes
    logic [7:0] exp_data [$];
    logic       exp_last [$];
    logic [7:0] rx_log [$];
    int         exp_idx = 0, hi_run = 0;

    always @(negedge clock) begin
        if (cs === 1'b1) hi_run++;
        else begin
            if (hi_run > 0) chk("cs_high_gap", 64'(hi_run >= CSH), 64'd1);
            hi_run = 0;
        end
        if (!reset_n) exp_idx = exp_data.size();
        else begin
            if (resp_valid) chk("resp_valid_expected", 64'(exp_idx < exp_data.size()), 64'd1);
            if (resp_valid && resp_ready && exp_idx < exp_data.size()) begin
                chk("resp_data", 64'(resp_data), 64'(exp_data[exp_idx]));
                chk("resp_last", 64'(resp_last), 64'(exp_last[exp_idx]));
                rx_log.push_back(resp_data);
                exp_idx++;
            end
        end
    end

    task automatic issue(input logic [31:0] a, input int len, input logic q);
        int n = 0;
        @(posedge clock); #1;
        req_valid = 1'b1; req_addr = a; req_len = LEN_BITS'(len); req_quad = q;
        for (int i = 0; i < len; i++) begin
            exp_data.push_back(mem[8'(a + 32'(i))]);
            exp_last.push_back(i == len - 1);
        end
        while (!req_ready && n < 2000) begin @(posedge clock); #1; n++; end
        chk("req_accept", 64'(n < 2000), 64'd1);
        @(posedge clock); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while ((exp_idx != exp_data.size() || cs !== 1'b1 || !req_ready) && n < 5000) begin
            @(posedge clock); #1; n++;
        end
        chk({nm, "_done"}, 64'(n < 5000), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, n, hi, falls0, lows;
        logic ok;
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 7 + 3);
        mem[8'h10] = 8'hA1; mem[8'h11] = 8'hB2; mem[8'h12] = 8'hC3; mem[8'h13] = 8'hD4;

        #1 reset_n = 1'b0;
        #2;
        chk("rst_sck", 64'(sck), 64'd0);
        chk("rst_cs", 64'(cs), 64'd1);
        chk("rst_dq_drive", 64'(dq_drive), 64'd0);
        chk("rst_dq_out", 64'(dq_out), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_last", 64'(resp_last), 64'd0);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b1;

        // single fast read
        base = rx_log.size();
        issue(32'h10, 4, 1'b0);
        wait_done("single");
        chk("single_cmd", 64'(last_cmd), 64'(C_S));
        chk("single_addr", 64'(last_addr), 64'h10);
        chk("single_sck", 64'(last_rises), (AB == 24) ? 64'd72 : 64'd80);
        chk("single_drive", 64'(last_bad), 64'd0);
        chk("single_cnt", 64'(rx_log.size()), 64'(base + 4));
        chk("single_b0", 64'(rx_log[base]), 64'hA1);
        chk("single_b3", 64'(rx_log[base + 3]), 64'hD4);

        // quad read
        base = rx_log.size();
        issue(32'h10, 4, 1'b1);
        wait_done("quad");
        chk("quad_cmd", 64'(last_cmd), 64'(C_Q));
        chk("quad_addr", 64'(last_addr), 64'h10);
        chk("quad_sck", 64'(last_rises), (AB == 24) ? 64'd30 : 64'd32);
        chk("quad_drive", 64'(last_bad), 64'd0);
        chk("quad_cnt", 64'(rx_log.size()), 64'(base + 4));
        chk("quad_b1", 64'(rx_log[base + 1]), 64'hB2);
        chk("quad_b2", 64'(rx_log[base + 2]), 64'hC3);

        // backpressure: hold the first byte, SCK must park low
        base = rx_log.size();
        issue(32'h11, 3, 1'b0);
        n = 0;
        while (!resp_valid && n < 2000) begin @(posedge clock); #1; n++; end
        chk("bp_first_valid", 64'(resp_valid), 64'd1);
        resp_ready = 1'b0;
        hi = 0;
        for (int i = 0; i < 50; i++) begin
            @(posedge clock); #1;
            if (i >= 10 && sck) hi++;
        end
        chk("bp_sck_low", 64'(hi), 64'd0);
        chk("bp_hold_valid", 64'(resp_valid), 64'd1);
        chk("bp_hold_data", 64'(resp_data), 64'hB2);
        resp_ready = 1'b1;
        wait_done("bp");
        chk("bp_cnt", 64'(rx_log.size()), 64'(base + 3));
        chk("bp_b0", 64'(rx_log[base]), 64'hB2);
        chk("bp_b1", 64'(rx_log[base + 1]), 64'hC3);
        chk("bp_b2", 64'(rx_log[base + 2]), 64'hD4);

        // zero length: consumed without any flash traffic
        falls0 = n_txn;
        issue(32'h10, 0, 1'b0);
        ok = req_ready;
        if (!ok) begin @(posedge clock); #1; ok = req_ready; end
        chk("zero_ready", 64'(ok), 64'd1);
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clock); #1;
            if (!cs) lows++;
        end
        chk("zero_cs_low", 64'(lows), 64'd0);
        chk("zero_txn", 64'(n_txn), 64'(falls0));

        // reset during the second data byte
        base = rx_log.size();
        issue(32'h10, 4, 1'b0);
        n = 0;
        while (rx_log.size() == base && n < 3000) begin @(posedge clock); #1; n++; end
        chk("rst_mid_first", 64'(rx_log.size() > base), 64'd1);
        repeat (6) @(posedge clock);
        #2 reset_n = 1'b0;
        #1;
        chk("rst_mid_sck", 64'(sck), 64'd0);
        chk("rst_mid_cs", 64'(cs), 64'd1);
        chk("rst_mid_valid", 64'(resp_valid), 64'd0);
        chk("rst_mid_drive", 64'(dq_drive), 64'd0);
        repeat (3) @(posedge clock);
        #3 reset_n = 1'b1;
        base = rx_log.size();
        issue(32'h13, 1, 1'b0);
        wait_done("rst_after");
        chk("rst_after_cnt", 64'(rx_log.size()), 64'(base + 1));
        chk("rst_after_b0", 64'(rx_log[base]), 64'hD4);

        // back-to-back; upper address bits matter only with 4-byte addressing
        base = rx_log.size();
        issue(32'h20, 1, 1'b0);
        issue(32'hAB000030, 1, 1'b0);
        wait_done("b2b");
        chk("b2b_cmd", 64'(last_cmd), 64'(C_S));
        chk("b2b_addr", 64'(last_addr), (AB == 24) ? 64'h30 : 64'hAB000030);
        chk("b2b_sck", 64'(last_rises), (AB == 24) ? 64'd48 : 64'd56);
        chk("b2b_cnt", 64'(rx_log.size()), 64'(base + 2));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/spi_flash_read_master.md
Name: spi_flash_read_master

Overview:
- Host-side initiator for the serial flash interface: turns a byte-granular read request into an SPI/QSPI fast-read transaction and streams the returned bytes out over a valid/ready port.
- Sits between the SoC boot/ROM fetch path and the flash pins.
- Generates SCK from the system clock, mode 0: idle low, launch on falling edge, sample on rising edge.
- Supports single-lane fast read (0x0B) and quad address+data read (0xEB), each with 8 dummy cycles.

Parameters:
- CLK_DIV, 2, system clocks per SCK half-period; legal values 1..255.
- LEN_BITS, 8, width of the request byte count.
- CS_HIGH_CYCLES, 4, minimum system clocks CS stays high between transactions; minimum value 1.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted when req_valid && req_ready
- req_addr  in  32  flash byte address
- req_len  in  LEN_BITS  number of bytes to read
- req_quad  in  1  1 = quad read (0xEB), 0 = single fast read (0x0B)
- resp_valid  out  1  returned byte valid
- resp_data  out  8  returned byte
- resp_last  out  1  marks the final byte of the request
- resp_ready  in  1  consumer accepts the byte
- sck  out  1  SPI clock
- cs  out  1  chip select, active high = deselected
- dq_out  out  4  pad output data
- dq_drive  out  4  pad output enables
- dq_in  in  4  pad input data

Behaviour:
- Reset (async, reset_n=0) forces immediately: sck=0, cs=1, dq_drive=0, dq_out=0, resp_valid=0, resp_last=0, req_ready=0, state=IDLE. Reset mid-transaction aborts it with no further responses.
- req_ready=1 only in IDLE with the CS-high counter expired. On accept, latch addr, len, quad.
- req_len==0: request is consumed, no SPI traffic, no response, return to IDLE next cycle.
- States: IDLE -> CMD -> ADDR -> DUMMY -> DATA -> CS_HOLD -> IDLE.
- SCK timing:
  - Each SCK period is CLK_DIV clocks low, then CLK_DIV clocks high.
  - Outputs change only at the start of a low phase.
  - dq_in is registered on the clock edge that drives sck 0->1.
- CMD:
  - cs falls on the cycle after accept.
  - 8 bits, MSB first, on dq_out[0] with dq_drive=4'b0001, in both modes.
- ADDR:
  - Single mode: 24 bits on dq_out[0], MSB first.
  - Quad mode: 6 nibbles on dq_out[3:0] with dq_drive=4'b1111, MSB nibble first.
- DUMMY: 8 SCK cycles, dq_drive=0 in both modes.
- DATA:
  - dq_drive=0.
  - Single mode samples dq_in[1] (8 SCK per byte, MSB first).
  - Quad mode samples dq_in[3:0] (2 SCK per byte, high nibble first).
- Byte completion: on the rising-edge sample that completes a byte, load resp_data and set resp_valid. Set resp_last when the remaining count reaches 0.
- resp_valid holds until resp_ready is seen. A simultaneous resp_ready and new-byte load is legal and causes no gap.
- Backpressure:
  - Before the first rising edge of a new byte, if resp_valid && !resp_ready, SCK holds low for as long as needed.
  - SCK never glitches; the low phase just extends.
  - No byte is ever dropped or overwritten.
- Byte counter: LEN_BITS wide, decrements per byte. The flash auto-increments the address; the master issues no new command.
- End of transfer: after the last byte's sample, finish the high phase, drive sck low, then cs=1. CS_HOLD counts CS_HIGH_CYCLES before req_ready may assert.
- Address arithmetic: 24-bit mode uses req_addr[23:0] and ignores the upper bits. Wrap-around past the flash top is the flash's behaviour; the master does not check it.
- Total SCK cycles per request:
  - single: 8+24+8+8*len
  - quad: 8+6+8+2*len

Optional Feature:
- Macro SPI_FLASH_ADDR4_EN.
- Defined: 4-byte addressing. Commands are 0x0C (single) and 0xEC (quad). Address phase is 32 bits single or 8 nibbles quad, using all of req_addr.
- Undefined: 3-byte addressing with 0x0B/0xEB as above.

Test Plan:
- Single read: flash model preloaded bytes[0x10..0x13]=A1 B2 C3 D4; req_addr=0x10, len=4, quad=0, resp_ready=1 -> sck shows command 0x0B and address 0x000010; resp bytes A1,B2,C3,D4 with resp_last on D4; 72 SCK cycles between cs fall and cs rise.
- Quad read: same preload, quad=1, len=4 -> command 0xEB on dq[0]; address nibbles on dq[3:0]; same 4 bytes returned; 30 SCK cycles total.
- Backpressure: len=3, resp_ready held 0 for 50 clocks after the first byte -> sck stays low during the stall; all 3 bytes are delivered in order; no loss.
- Zero length: req_len=0 -> cs never falls; no resp_valid; req_ready returns within 2 cycles.
- Reset mid-DATA: assert reset_n=0 during the second byte -> sck=0, cs=1, resp_valid=0 immediately. After release, a new len=1 read at 0x13 returns D4.
- Back-to-back requests: cs is high for at least CS_HIGH_CYCLES clocks between transactions. With SPI_FLASH_ADDR4_EN, the command seen is 0x0C and the address phase is 32 bits.
